ex_muldiv: RTL
==============

EX_MULDIV -- requirements
Module: ex_muldiv

Interface
REQ-001 SHALL have port clk, input, 1, sole clock; all state updates on rising edge.
REQ-002 SHALL have port rst, input, 1, asynchronous active-low reset.
REQ-003 SHALL have port start, input, 1, request to begin operation; sampled only in IDLE.
REQ-004 SHALL have port op, input, 2, operation code: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
REQ-005 SHALL have port operand_1, input, 32, ID-stage operand 1 (multiplicand/dividend).
REQ-006 SHALL have port operand_2, input, 32, ID-stage operand 2 (multiplier/divisor).
REQ-007 SHALL have port flush, input, 1, abort any in-flight operation.
REQ-008 SHALL have ports hi_we/lo_we, input, 1 each, MTHI/MTLO write enables.
REQ-009 SHALL have port wdata, input, 32, MTHI/MTLO write data.
REQ-010 SHALL have port stall_req, output, 1, pipeline stall request.
REQ-011 SHALL have port done, output, 1, one-cycle completion pulse.
REQ-012 SHALL have ports hi/lo, output, 32 each, architectural HI/LO register contents.

Function
REQ-013 SHALL implement states IDLE, CALC, FINISH.
REQ-014 IDLE with start=1 and flush=0 SHALL latch op and operand magnitudes, clear 5-bit counter, enter CALC.
REQ-015 CALC SHALL perform one radix-2 step per cycle (shift-add multiply, restoring divide) for 32 cycles, then enter FINISH.
REQ-016 FINISH SHALL assert done=1 for exactly one cycle, write HI/LO on its closing edge, return to IDLE.
REQ-017 Latency: start accepted at edge N -> done high in cycle after edge N+32 -> hi/lo valid after edge N+33.
REQ-018 stall_req SHALL equal (state==IDLE && start) || state==CALC; stall_req=0 in FINISH.
REQ-019 Multiply: {hi,lo} = 64-bit product; MULT signed two's complement, MULTU unsigned.
REQ-020 Divide: lo=quotient, hi=remainder; signed quotient truncates toward zero, remainder takes dividend's sign.
REQ-021 Divide by zero SHALL produce lo=32'hFFFFFFFF, hi=operand_1 as latched, same latency.
REQ-022 Signed overflow 0x80000000 / -1 SHALL produce lo=0x80000000, hi=0.
REQ-023 start while state!=IDLE SHALL be ignored.
REQ-024 flush in any state SHALL force IDLE at next edge, done=0 that cycle, HI/LO unchanged.
REQ-025 flush and start together in IDLE: flush wins, no operation begins.
REQ-026 hi_we/lo_we SHALL update hi/lo from wdata at the edge, in any state.
REQ-027 When FINISH completion coincides with hi_we/lo_we, the multiply/divide result SHALL win.

Reset
REQ-028 rst low SHALL immediately force state=IDLE, counter=0, hi=0, lo=0, done=0, stall_req=0.
REQ-029 Reset mid-CALC SHALL discard the operation with no HI/LO write after release.

Configuration
REQ-030 Macro MULDIV_DIV_EN defined: divide datapath compiled in, REQ-020..022 apply.
REQ-031 MULDIV_DIV_EN undefined: op 10/11 SHALL go IDLE->FINISH directly (done one cycle after accept, stall only in accept cycle), HI/LO unchanged; no divider logic present.

Structure
REQ-032 Op encodings, state encodings and iteration count (32) SHALL live in shared header muldiv.v alongside bus.v.
REQ-033 The iterative datapath SHALL be sub-module muldiv_core (operands, op, step enable in; partial results out); ex_muldiv holds FSM, counter, sign fix-up, HI/LO.

Verification
REQ-034 MULTU 0xFFFFFFFF*0xFFFFFFFF -> after 33 edges hi=0xFFFFFFFE, lo=0x00000001, done one cycle.
REQ-035 MULT -3*7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB; stall_req high for 33 cycles from start.
REQ-036 DIV -7/2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; DIVU 100/0 -> lo=0xFFFFFFFF, hi=100.
REQ-037 flush at CALC cycle 10 of MULTU 5*5 -> IDLE next cycle, no done, hi/lo retain prior values.
REQ-038 lo_we=1 wdata=0x1234 in FINISH of MULTU 2*3 -> lo=6; lo_we in IDLE -> lo=0x1234.
REQ-039 rst low mid-CALC then released -> hi=lo=0, done never asserted; second start during CALC ignored.

Source files
------------

// File: rtl/ex_muldiv_pkg.sv
// Shared encodings, sizes and helpers for the EX-stage iterative multiply/divide unit.
// The divide datapath is present only when MULDIV_DIV_EN is defined.
package ex_muldiv_pkg;

    localparam int unsigned XLEN       = 32;
    localparam int unsigned CNT_W      = 5;
    localparam int unsigned ITERATIONS = 32;

    typedef enum logic [1:0] {
        OP_MULT  = 2'b00,
        OP_MULTU = 2'b01,
        OP_DIV   = 2'b10,
        OP_DIVU  = 2'b11
    } muldiv_op_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_CALC   = 2'b01,
        ST_FINISH = 2'b10
    } muldiv_state_e;

    typedef struct packed {
        logic [XLEN-1:0] hi;
        logic [XLEN-1:0] lo;
    } hilo_t;

    // Two's-complement negate when neg is set; also yields the magnitude of a signed value.
    function automatic logic [XLEN-1:0] cond_negate(input logic [XLEN-1:0] x, input logic neg);
        return neg ? -x : x;
    endfunction

    function automatic logic op_is_div(input muldiv_op_e op);
        return (op == OP_DIV) || (op == OP_DIVU);
    endfunction

endpackage

// File: rtl/muldiv_core.sv
// Radix-2 iterative datapath: shift-add multiply and (with MULDIV_DIV_EN) restoring divide.
// Works on unsigned magnitudes; sign handling lives in the parent.
module muldiv_core
    import ex_muldiv_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            load,
    input  logic            step,
    input  logic            div_sel,
    input  logic [XLEN-1:0] mag_1,
    input  logic [XLEN-1:0] mag_2,
    output logic [XLEN-1:0] part_hi,
    output logic [XLEN-1:0] part_lo
);

    logic [XLEN-1:0] acc_hi;
    logic [XLEN-1:0] acc_lo;
    logic [XLEN-1:0] opnd;
    logic [XLEN-1:0] nxt_hi;
    logic [XLEN-1:0] nxt_lo;
    logic [XLEN:0]   mul_sum;

    // Multiply: acc_lo holds the multiplier, product bits shift in from the top.
    always_comb begin
        mul_sum = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd} : '0);
    end

`ifdef MULDIV_DIV_EN
    logic            mode_div;
    logic [XLEN:0]   shifted;
    logic            fits;
    logic [XLEN-1:0] diff;

    // Divide: acc_hi is the partial remainder, acc_lo shifts dividend out and quotient in.
    always_comb begin
        shifted = {acc_hi, acc_lo[XLEN-1]};
        fits    = shifted >= {1'b0, opnd};
        diff    = shifted[XLEN-1:0] - opnd;
        if (!mode_div) begin
            nxt_hi = mul_sum[XLEN:1];
            nxt_lo = {mul_sum[0], acc_lo[XLEN-1:1]};
        end else if (fits) begin
            nxt_hi = diff;
            nxt_lo = {acc_lo[XLEN-2:0], 1'b1};
        end else begin
            nxt_hi = shifted[XLEN-1:0];
            nxt_lo = {acc_lo[XLEN-2:0], 1'b0};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc_hi   <= '0;
            acc_lo   <= '0;
            opnd     <= '0;
            mode_div <= 1'b0;
        end else if (load) begin
            acc_hi   <= '0;
            acc_lo   <= div_sel ? mag_1 : mag_2;
            opnd     <= div_sel ? mag_2 : mag_1;
            mode_div <= div_sel;
        end else if (step) begin
            acc_hi   <= nxt_hi;
            acc_lo   <= nxt_lo;
        end
    end
`else
    logic unused_div_sel;
    assign unused_div_sel = div_sel;

    always_comb begin
        nxt_hi = mul_sum[XLEN:1];
        nxt_lo = {mul_sum[0], acc_lo[XLEN-1:1]};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc_hi <= '0;
            acc_lo <= '0;
            opnd   <= '0;
        end else if (load) begin
            acc_hi <= '0;
            acc_lo <= mag_2;
            opnd   <= mag_1;
        end else if (step) begin
            acc_hi <= nxt_hi;
            acc_lo <= nxt_lo;
        end
    end
`endif

    assign part_hi = acc_hi;
    assign part_lo = acc_lo;

endmodule

// File: rtl/ex_muldiv.sv
// EX-stage multiply/divide unit: FSM, iteration counter, sign fix-up and HI/LO registers.
// Define MULDIV_DIV_EN to build the divider; otherwise DIV/DIVU complete immediately without writing HI/LO.
module ex_muldiv
    import ex_muldiv_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [1:0]      op,
    input  logic [XLEN-1:0] operand_1,
    input  logic [XLEN-1:0] operand_2,
    input  logic            flush,
    input  logic            hi_we,
    input  logic            lo_we,
    input  logic [XLEN-1:0] wdata,
    output logic            stall_req,
    output logic            done,
    output logic [XLEN-1:0] hi,
    output logic [XLEN-1:0] lo
);

    muldiv_state_e    state;
    muldiv_state_e    state_nx;
    logic [CNT_W-1:0] cnt;
    muldiv_op_e       op_q;
    logic             neg_q;
    logic             accept;
    logic             core_step;
    logic             wr_result;
    logic             result_ok;
    logic             sgn_1;
    logic             sgn_2;
    logic [XLEN-1:0]  mag_1;
    logic [XLEN-1:0]  mag_2;
    logic [XLEN-1:0]  part_hi;
    logic [XLEN-1:0]  part_lo;
    logic [2*XLEN-1:0] product;
    hilo_t            result;

`ifdef MULDIV_DIV_EN
    logic             rem_neg_q;
    logic             div_zero_q;
    logic [XLEN-1:0]  opnd1_q;
    assign result_ok = 1'b1;
`else
    assign result_ok = !op_is_div(op_q);
`endif

    // Signed ops (MULT, DIV) have op[0] clear.
    always_comb begin
        sgn_1 = !op[0] && operand_1[XLEN-1];
        sgn_2 = !op[0] && operand_2[XLEN-1];
        mag_1 = cond_negate(operand_1, sgn_1);
        mag_2 = cond_negate(operand_2, sgn_2);
    end

    muldiv_core u_core (
        .clk     (clk),
        .rst     (rst),
        .load    (accept),
        .step    (core_step),
        .div_sel (op[1]),
        .mag_1   (mag_1),
        .mag_2   (mag_2),
        .part_hi (part_hi),
        .part_lo (part_lo)
    );

    always_comb begin
        state_nx  = state;
        accept    = 1'b0;
        core_step = 1'b0;
        wr_result = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    accept = 1'b1;
`ifdef MULDIV_DIV_EN
                    state_nx = ST_CALC;
`else
                    state_nx = op[1] ? ST_FINISH : ST_CALC;
`endif
                end
            end
            ST_CALC: begin
                core_step = 1'b1;
                if (cnt == CNT_W'(ITERATIONS - 1)) begin
                    state_nx = ST_FINISH;
                end
            end
            ST_FINISH: begin
                wr_result = result_ok;
                state_nx  = ST_IDLE;
            end
            default: state_nx = ST_IDLE;
        endcase
        // Flush overrides everything, including a simultaneous start.
        if (flush) begin
            state_nx  = ST_IDLE;
            accept    = 1'b0;
            core_step = 1'b0;
            wr_result = 1'b0;
        end
    end

    assign stall_req = ((state == ST_IDLE) && start) || (state == ST_CALC);
    assign done      = (state == ST_FINISH) && !flush;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            op_q       <= OP_MULT;
            neg_q      <= 1'b0;
`ifdef MULDIV_DIV_EN
            rem_neg_q  <= 1'b0;
            div_zero_q <= 1'b0;
            opnd1_q    <= '0;
`endif
        end else begin
            state <= state_nx;
            if (accept) begin
                cnt        <= '0;
                op_q       <= muldiv_op_e'(op);
                neg_q      <= sgn_1 ^ sgn_2;
`ifdef MULDIV_DIV_EN
                rem_neg_q  <= sgn_1;
                div_zero_q <= (operand_2 == '0);
                opnd1_q    <= operand_1;
`endif
            end else if (core_step) begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

    // Sign fix-up of the magnitude result into architectural HI/LO form.
    always_comb begin
        product = {part_hi, part_lo};
        result  = hilo_t'(neg_q ? -product : product);
`ifdef MULDIV_DIV_EN
        if (op_is_div(op_q)) begin
            if (div_zero_q) begin
                result.hi = opnd1_q;
                result.lo = '1;
            end else begin
                result.hi = cond_negate(part_hi, rem_neg_q);
                result.lo = cond_negate(part_lo, neg_q);
            end
        end
`endif
    end

    // A completing operation takes priority over MTHI/MTLO in the same cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hi <= '0;
            lo <= '0;
        end else if (wr_result) begin
            hi <= result.hi;
            lo <= result.lo;
        end else begin
            if (hi_we) hi <= wdata;
            if (lo_we) lo <= wdata;
        end
    end

endmodule
